// File: rtl/aes128_dec_arbiter_pkg.sv
// Shared types and constants for the AES-128 decrypt-engine arbiter.
package aes128_dec_arbiter_pkg;

  localparam int unsigned AES_BLK_W = 128;

  typedef logic [AES_BLK_W-1:0] aes_blk_t;

  typedef enum logic [1:0] {IDLE_S, ISSUE_S, WAIT_S, RESP_S} arb_state_t;

  // Requester index following idx, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/aes128_dec_arbiter_if.sv
// Request, engine and response buses of the AES-128 decrypt arbiter.
// Signal names carry the direction as seen from the arbiter (slave modport).
interface aes128_dec_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) ();
  import aes128_dec_arbiter_pkg::*;

  logic [NUM_REQ-1:0]           req_valid_i;
  logic [NUM_REQ-1:0]           req_ready_o;
  logic [NUM_REQ*AES_BLK_W-1:0] req_key_i;
  logic [NUM_REQ*AES_BLK_W-1:0] req_cipher_i;

  logic                         core_start_o;
  aes_blk_t                     core_key_o;
  aes_blk_t                     core_cipher_o;
  logic                         core_ready_i;
  logic                         core_done_i;
  aes_blk_t                     core_plain_i;

  logic                         rsp_valid_o;
  logic                         rsp_ready_i;
  logic [ID_W-1:0]              rsp_id_o;
  aes_blk_t                     rsp_plain_o;
  logic                         rsp_err_o;

  modport slave (
    input  req_valid_i, req_key_i, req_cipher_i,
    input  core_ready_i, core_done_i, core_plain_i,
    input  rsp_ready_i,
    output req_ready_o,
    output core_start_o, core_key_o, core_cipher_o,
    output rsp_valid_o, rsp_id_o, rsp_plain_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_key_i, req_cipher_i,
    output core_ready_i, core_done_i, core_plain_i,
    output rsp_ready_i,
    input  req_ready_o,
    input  core_start_o, core_key_o, core_cipher_o,
    input  rsp_valid_o, rsp_id_o, rsp_plain_o, rsp_err_o
  );

endinterface

// File: rtl/aes128_dec_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or above
// ptr_i, searching upward with wrap-around.
module aes128_dec_arbiter_rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_onehot_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             any_gnt_o
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    idx          = '0;
    gnt_onehot_o = '0;
    gnt_idx_o    = '0;
    any_gnt_o    = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IDX_W'((32'(ptr_i) + k) % N);
      if (!any_gnt_o && req_i[idx]) begin
        any_gnt_o         = 1'b1;
        gnt_idx_o         = idx;
        gnt_onehot_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes128_dec_arbiter.sv
// Shares one AES-128 decrypt engine between NUM_REQ requesters with round-robin
// grant, a completion watchdog and an ID-tagged response channel.
module aes128_dec_arbiter
  import aes128_dec_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_W        = $clog2(NUM_REQ),
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst,
  aes128_dec_arbiter_if.slave bus,
  output logic                busy_o
);

  localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  arb_state_t      state_q;
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] id_q;
  aes_blk_t        key_q;
  aes_blk_t        cipher_q;
  aes_blk_t        plain_q;
  logic            start_q;
  logic            rsp_valid_q;
  logic            rsp_err_q;
  logic [WD_W-1:0] wd_q;

  logic [NUM_REQ-1:0] gnt_onehot;
  logic [ID_W-1:0]    gnt_idx;
  logic               any_gnt;
  logic               grant_en;
  aes_blk_t           sel_key;
  aes_blk_t           sel_cipher;

  aes128_dec_arbiter_rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr_arbiter (
    .req_i        (bus.req_valid_i),
    .ptr_i        (rr_ptr_q),
    .gnt_onehot_o (gnt_onehot),
    .gnt_idx_o    (gnt_idx),
    .any_gnt_o    (any_gnt)
  );

  // The handshake completes in the grant cycle, so ready is combinational.
  assign grant_en        = !rst && (state_q == IDLE_S) && bus.core_ready_i && any_gnt;
  assign bus.req_ready_o = grant_en ? gnt_onehot : '0;

  always_comb begin
    sel_key    = '0;
    sel_cipher = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_onehot[i]) begin
        sel_key    = bus.req_key_i[i*AES_BLK_W +: AES_BLK_W];
        sel_cipher = bus.req_cipher_i[i*AES_BLK_W +: AES_BLK_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE_S;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      key_q       <= '0;
      cipher_q    <= '0;
      plain_q     <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      wd_q        <= '0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        IDLE_S: begin
          if (grant_en) begin
            key_q    <= sel_key;
            cipher_q <= sel_cipher;
            id_q     <= gnt_idx;
            rr_ptr_q <= ID_W'(rr_next(32'(gnt_idx), NUM_REQ));
            start_q  <= 1'b1;
            state_q  <= ISSUE_S;
          end
        end
        ISSUE_S: begin
          wd_q    <= '0;
          state_q <= WAIT_S;
        end
        WAIT_S: begin
          wd_q <= wd_q + 1'b1;
          // A completion in the final watchdog cycle still returns real data.
          if (bus.core_done_i) begin
            plain_q     <= bus.core_plain_i;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP_S;
          end else if (wd_q == WD_LAST) begin
            plain_q     <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP_S;
          end
        end
        RESP_S: begin
          if (rsp_valid_q && bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE_S;
          end
        end
        default: state_q <= IDLE_S;
      endcase
    end
  end

  assign bus.core_start_o  = start_q;
  assign bus.core_key_o    = key_q;
  assign bus.core_cipher_o = cipher_q;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_id_o      = id_q;
  assign bus.rsp_plain_o   = plain_q;
  assign bus.rsp_err_o     = rsp_err_q;
  assign busy_o            = (state_q != IDLE_S);

endmodule

// File: tb/tb_aes128_dec_arbiter.sv
// Directed bench for aes128_dec_arbiter with an engine stand-in that answers the
// FIPS-197 known-answer vector and returns key^cipher for any other operands.
module tb_aes128_dec_arbiter;
  import aes128_dec_arbiter_pkg::*;

  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned ID_W        = 2;
  localparam int unsigned TIMEOUT_CYC = 16;
  localparam int          ENG_LAT     = 10;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  typedef struct packed {
    logic            err;
    logic [ID_W-1:0] id;
    logic [127:0]    plain;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  aes128_dec_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  aes128_dec_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .ID_W        (ID_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Engine stand-in: latches operands on start, answers ENG_LAT cycles later.
  logic         eng_rst, eng_mute, force_done, eng_busy;
  int           eng_cnt;
  logic [127:0] eng_key, eng_ct;

  function automatic logic [127:0] eng_model(input logic [127:0] k, input logic [127:0] c);
    if (k == FIPS_KEY && c == FIPS_CT) return FIPS_PT;
    return k ^ c;
  endfunction

  always @(posedge clk) begin
    bus.core_done_i <= 1'b0;
    if (eng_rst) begin
      eng_busy <= 1'b0;
      eng_cnt  <= 0;
    end else if (force_done) begin
      bus.core_done_i  <= 1'b1;
      bus.core_plain_i <= '1;
    end else if (eng_busy) begin
      if (!eng_mute) begin
        if (eng_cnt == 1) begin
          eng_busy         <= 1'b0;
          bus.core_done_i  <= 1'b1;
          bus.core_plain_i <= eng_model(eng_key, eng_ct);
        end
        eng_cnt <= eng_cnt - 1;
      end
    end else if (bus.core_start_o) begin
      eng_busy <= 1'b1;
      eng_cnt  <= ENG_LAT;
      eng_key  <= bus.core_key_o;
      eng_ct   <= bus.core_cipher_o;
    end
  end

  assign bus.core_ready_i = ~eng_busy;

  logic [NUM_REQ-1:0] ready_smp;
  logic               auto_drop;
  int                 gnt_log[$];
  rsp_t               rsp_log[$];

  function automatic int oh2idx(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [127:0] tkey(input int i);
    return {4{32'hA5A5_0000 | 32'(i)}};
  endfunction

  function automatic logic [127:0] tcip(input int i);
    return {4{32'h0000_3C00 | (32'(i) << 4)}};
  endfunction

  task automatic set_req(input int i, input logic [127:0] k, input logic [127:0] c);
    bus.req_key_i[i*128 +: 128]    = k;
    bus.req_cipher_i[i*128 +: 128] = c;
  endtask

  // Sample on the falling edge, then let one rising edge pass; returns 1 after it.
  task automatic step();
    @(negedge clk);
    ready_smp = bus.req_ready_o;
    if (ready_smp != '0) gnt_log.push_back(oh2idx(ready_smp));
    if (bus.rsp_valid_o && bus.rsp_ready_i)
      rsp_log.push_back('{err: bus.rsp_err_o, id: bus.rsp_id_o, plain: bus.rsp_plain_o});
    @(posedge clk);
    #1;
    if (auto_drop) bus.req_valid_i = bus.req_valid_i & ~ready_smp;
  endtask

  task automatic do_reset();
    rst = 1'b1; eng_rst = 1'b1; eng_mute = 1'b0; force_done = 1'b0;
    bus.req_valid_i = '0; bus.rsp_ready_i = 1'b1; auto_drop = 1'b1;
    step(); step();
    rst = 1'b0; eng_rst = 1'b0;
    gnt_log.delete(); rsp_log.delete();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((busy || !bus.core_ready_i) && n < 200) begin step(); n++; end
    checks++;
    if (n >= 200) begin fails++; $display("FAIL %s_drain: still busy after %0d cycles", name, n); end
  endtask

  task automatic test_reset();
    rst = 1'b1; eng_rst = 1'b1; eng_mute = 1'b0; force_done = 1'b0;
    bus.rsp_ready_i = 1'b1; auto_drop = 1'b0;
    bus.req_valid_i = '1;
    step(); step();
    checks++; if (ready_smp !== 4'b0000) begin fails++;
      $display("FAIL reset_ready: got %b expected 0000", ready_smp); end
    checks++; if (bus.core_start_o !== 1'b0) begin fails++;
      $display("FAIL reset_start: got %b expected 0", bus.core_start_o); end
    checks++; if (bus.core_key_o !== '0 || bus.core_cipher_o !== '0) begin fails++;
      $display("FAIL reset_operands: got %h/%h expected 0", bus.core_key_o, bus.core_cipher_o); end
    checks++; if (bus.rsp_valid_o !== 1'b0 || bus.rsp_err_o !== 1'b0) begin fails++;
      $display("FAIL reset_rsp_flags: got v=%b e=%b expected 0", bus.rsp_valid_o, bus.rsp_err_o); end
    checks++; if (bus.rsp_id_o !== '0 || bus.rsp_plain_o !== '0) begin fails++;
      $display("FAIL reset_rsp_data: got %h/%h expected 0", bus.rsp_id_o, bus.rsp_plain_o); end
    checks++; if (busy !== 1'b0) begin fails++;
      $display("FAIL reset_busy: got %b expected 0", busy); end
    bus.req_valid_i = '0;
    rst = 1'b0; eng_rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int n = 0;
    do_reset();
    set_req(1, FIPS_KEY, FIPS_CT);
    bus.req_valid_i = 4'b0010;
    step();
    checks++; if (ready_smp !== 4'b0010) begin fails++;
      $display("FAIL t1_grant: got %b expected 0010", ready_smp); end
    checks++; if (bus.core_start_o !== 1'b1) begin fails++;
      $display("FAIL t1_start: got %b expected 1 in cycle after grant", bus.core_start_o); end
    step();
    checks++; if (bus.core_start_o !== 1'b0 || bus.core_key_o !== FIPS_KEY) begin fails++;
      $display("FAIL t1_issue: got start=%b key=%h expected 0/%h",
               bus.core_start_o, bus.core_key_o, FIPS_KEY); end
    while (bus.core_done_i !== 1'b1 && n < 100) begin step(); n++; end
    checks++; if (n >= 100 || bus.rsp_valid_o !== 1'b0) begin fails++;
      $display("FAIL t1_done: got n=%0d valid=%b expected done, valid=0", n, bus.rsp_valid_o); end
    step();
    checks++; if (bus.rsp_valid_o !== 1'b1) begin fails++;
      $display("FAIL t1_rsp_latency: got valid=%b expected 1", bus.rsp_valid_o); end
    checks++; if (bus.rsp_id_o !== 2'd1 || bus.rsp_plain_o !== FIPS_PT || bus.rsp_err_o !== 1'b0)
      begin fails++;
      $display("FAIL t1_rsp: got id=%0d plain=%h err=%b expected 1/%h/0",
               bus.rsp_id_o, bus.rsp_plain_o, bus.rsp_err_o, FIPS_PT); end
    step();
    checks++; if (bus.rsp_valid_o !== 1'b0 || busy !== 1'b0) begin fails++;
      $display("FAIL t1_release: got valid=%b busy=%b expected 0/0", bus.rsp_valid_o, busy); end
  endtask

  task automatic test_simultaneous();
    int n = 0;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, tkey(i), tcip(i));
    bus.req_valid_i = 4'b1111;
    while (rsp_log.size() < 4 && n < 400) begin step(); n++; end
    checks++; if (gnt_log.size() != 4 || rsp_log.size() != 4) begin fails++;
      $display("FAIL t2_count: got %0d grants %0d rsps expected 4/4",
               gnt_log.size(), rsp_log.size()); end
    for (int i = 0; i < gnt_log.size() && i < 4; i++) begin
      checks++; if (gnt_log[i] != i) begin fails++;
        $display("FAIL t2_order[%0d]: got %0d expected %0d", i, gnt_log[i], i); end
    end
    for (int i = 0; i < rsp_log.size() && i < 4; i++) begin
      checks++;
      if (rsp_log[i].id !== ID_W'(i) || rsp_log[i].plain !== (tkey(i) ^ tcip(i)) ||
          rsp_log[i].err !== 1'b0) begin fails++;
        $display("FAIL t2_rsp[%0d]: got id=%0d plain=%h err=%b expected %0d/%h/0", i,
                 rsp_log[i].id, rsp_log[i].plain, rsp_log[i].err, i, tkey(i) ^ tcip(i)); end
    end
    drain("t2");
  endtask

  task automatic test_fairness();
    int exp_ord[4] = '{0, 2, 0, 2};
    int n = 0;
    do_reset();
    auto_drop = 1'b0;
    set_req(0, tkey(0), tcip(0));
    set_req(2, tkey(2), tcip(2));
    bus.req_valid_i = 4'b0101;
    while (gnt_log.size() < 4 && n < 400) begin step(); n++; end
    bus.req_valid_i = '0;
    auto_drop = 1'b1;
    checks++; if (gnt_log.size() != 4) begin fails++;
      $display("FAIL t3_count: got %0d grants expected 4", gnt_log.size()); end
    for (int i = 0; i < gnt_log.size() && i < 4; i++) begin
      checks++; if (gnt_log[i] != exp_ord[i]) begin fails++;
        $display("FAIL t3_order[%0d]: got %0d expected %0d", i, gnt_log[i], exp_ord[i]); end
    end
    drain("t3");
  endtask

  task automatic test_backpressure();
    int n = 0;
    logic stable = 1'b1;
    logic leaked = 1'b0;
    rsp_t snap;
    do_reset();
    bus.rsp_ready_i = 1'b0;
    set_req(3, tkey(3), tcip(3));
    bus.req_valid_i = 4'b1000;
    while (bus.rsp_valid_o !== 1'b1 && n < 100) begin step(); n++; end
    snap = '{err: bus.rsp_err_o, id: bus.rsp_id_o, plain: bus.rsp_plain_o};
    checks++; if (snap.id !== 2'd3 || snap.plain !== (tkey(3) ^ tcip(3)) || snap.err !== 1'b0)
      begin fails++;
      $display("FAIL t4_rsp: got id=%0d plain=%h err=%b expected 3/%h/0",
               snap.id, snap.plain, snap.err, tkey(3) ^ tcip(3)); end
    set_req(0, tkey(0), tcip(0));
    bus.req_valid_i = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_id_o !== snap.id ||
          bus.rsp_plain_o !== snap.plain || bus.rsp_err_o !== snap.err) stable = 1'b0;
      if (ready_smp !== 4'b0000) leaked = 1'b1;
    end
    checks++; if (!stable) begin fails++;
      $display("FAIL t4_stable: got rsp change under backpressure expected hold"); end
    checks++; if (leaked) begin fails++;
      $display("FAIL t4_no_grant: got req_ready during RESP expected 0000"); end
    bus.rsp_ready_i = 1'b1;
    step();
    step();
    checks++; if (ready_smp !== 4'b0001) begin fails++;
      $display("FAIL t4_regrant: got %b expected 0001", ready_smp); end
    drain("t4");
  endtask

  task automatic test_timeout();
    int n = 0;
    logic blocked = 1'b0;
    do_reset();
    eng_mute = 1'b1;
    bus.rsp_ready_i = 1'b0;
    set_req(2, tkey(2), tcip(2));
    bus.req_valid_i = 4'b0100;
    while (bus.core_start_o !== 1'b1 && n < 10) begin step(); n++; end
    n = 0;
    while (n < 100) begin
      step();
      if (bus.rsp_valid_o === 1'b1) break;
      n++;
    end
    checks++; if (n != TIMEOUT_CYC) begin fails++;
      $display("FAIL t5_wait_cycles: got %0d expected %0d", n, TIMEOUT_CYC); end
    checks++; if (bus.rsp_err_o !== 1'b1 || bus.rsp_plain_o !== '0 || bus.rsp_id_o !== 2'd2)
      begin fails++;
      $display("FAIL t5_err_rsp: got err=%b plain=%h id=%0d expected 1/0/2",
               bus.rsp_err_o, bus.rsp_plain_o, bus.rsp_id_o); end
    force_done = 1'b1;
    step();
    force_done = 1'b0;
    step(); step();
    checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== 1'b1 || bus.rsp_plain_o !== '0)
      begin fails++;
      $display("FAIL t5_late_done: got v=%b err=%b plain=%h expected 1/1/0",
               bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_plain_o); end
    set_req(0, tkey(0), tcip(0));
    bus.req_valid_i = 4'b0001;
    bus.rsp_ready_i = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      if (ready_smp !== 4'b0000 || busy !== 1'b0) blocked = 1'b1;
    end
    checks++; if (blocked) begin fails++;
      $display("FAIL t5_wait_core_ready: got grant or busy while engine stuck expected none"); end
    eng_rst = 1'b1; eng_mute = 1'b0;
    step();
    eng_rst = 1'b0;
    n = 0;
    while (ready_smp === 4'b0000 && n < 10) begin step(); n++; end
    checks++; if (ready_smp !== 4'b0001) begin fails++;
      $display("FAIL t5_recover: got %b expected 0001", ready_smp); end
    drain("t5");
  endtask

  task automatic test_reset_mid_wait();
    int n = 0;
    do_reset();
    set_req(0, tkey(0), tcip(0));
    set_req(1, tkey(1), tcip(1));
    bus.req_valid_i = 4'b0001;
    while (bus.core_start_o !== 1'b1 && n < 10) begin step(); n++; end
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 4'b0000)
      begin fails++;
      $display("FAIL t6_after_reset: got busy=%b valid=%b ready=%b expected 0/0/0000",
               busy, bus.rsp_valid_o, bus.req_ready_o); end
    n = 0;
    while (bus.core_ready_i !== 1'b1 && n < 50) begin step(); n++; end
    step();
    checks++; if (bus.rsp_valid_o !== 1'b0) begin fails++;
      $display("FAIL t6_stale_done: got valid=%b expected 0", bus.rsp_valid_o); end
    bus.req_valid_i = 4'b0011;
    step();
    checks++; if (ready_smp !== 4'b0001) begin fails++;
      $display("FAIL t6_rr_ptr: got %b expected 0001", ready_smp); end
    bus.req_valid_i = '0;
    drain("t6");
  endtask

  initial begin
    rst = 1'b1; eng_rst = 1'b1; eng_mute = 1'b0; force_done = 1'b0; auto_drop = 1'b0;
    ready_smp = '0;
    bus.req_valid_i = '0; bus.req_key_i = '0; bus.req_cipher_i = '0; bus.rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_timeout();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish by 400000 ns expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
